// File: rtl/mux_2_1_32.sv
// Next-PC 2:1 word select: C = Sel ? B : A, zero-cycle latency, no backpressure.
// Registered observation copies (C_q, Sel_q, saturating B_count) lag by one CLK edge.
module mux_2_1_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sel,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] C_q,
  output logic             Sel_q,
  output logic [CNT_W-1:0] B_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // An unknown or floating select falls through to A (sequential fetch).
  always_comb begin
    C = A;
    if (Sel) begin
      C = B;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      C_q     <= '0;
      Sel_q   <= 1'b0;
      B_count <= '0;
    end else begin
      C_q <= C;
      if (Sel) begin
        Sel_q <= 1'b1;
        if (B_count != CNT_MAX) begin
          B_count <= B_count + CNT_ONE;
        end
      end else begin
        Sel_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_2_1_32.sv
// Scoreboard bench for mux_2_1_32: a driver pushes expectations, a monitor pops and compares.
module tb_mux_2_1_32;

  logic        CLK;
  logic        Reset;
  logic [31:0] A, B;
  logic        Sel;
  logic [31:0] C, C_q;
  logic        Sel_q;
  logic [15:0] B_count;
  logic [7:0]  c_s, cq_s;
  logic        selq_s;
  logic [1:0]  bcnt_s;

  mux_2_1_32 #(.WIDTH(32), .CNT_W(16)) dut (
    .CLK(CLK), .Reset(Reset), .A(A), .B(B), .Sel(Sel),
    .C(C), .C_q(C_q), .Sel_q(Sel_q), .B_count(B_count)
  );

  mux_2_1_32 #(.WIDTH(8), .CNT_W(2)) dut_s (
    .CLK(CLK), .Reset(Reset), .A(A[7:0]), .B(B[7:0]), .Sel(Sel),
    .C(c_s), .C_q(cq_s), .Sel_q(selq_s), .B_count(bcnt_s)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] c;
    logic [31:0] cq;
    logic        selq;
    int          cnt;
    int          cnt_s;
    bit          regs;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference state: what the observation registers should hold after the edges so far.
  logic [31:0] m_cq;
  logic        m_selq;
  int          m_cnt, m_cnt_s;
  bit          m_known = 0;
  bit          started = 0;

  function automatic logic [31:0] ref_c(input logic s, input logic [31:0] a, input logic [31:0] b);
    return (s === 1'b1) ? b : a;
  endfunction

  task automatic apply_edge();
    if (Reset === 1'b1) begin
      m_cq = 0; m_selq = 0; m_cnt = 0; m_cnt_s = 0; m_known = 1;
    end else begin
      m_cq   = ref_c(Sel, A, B);
      m_selq = (Sel === 1'b1);
      if (Sel === 1'b1) begin
        m_cnt   = (m_cnt   < 65535) ? m_cnt + 1   : 65535;
        m_cnt_s = (m_cnt_s < 3)     ? m_cnt_s + 1 : 3;
      end
    end
  endtask

  task automatic push(input string nm);
    exp_t e;
    e.c = ref_c(Sel, A, B); e.cq = m_cq; e.selq = m_selq;
    e.cnt = m_cnt; e.cnt_s = m_cnt_s; e.regs = m_known;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic step(input logic rst, input logic s, input logic [31:0] a, input logic [31:0] b,
                      input string nm);
    @(negedge CLK);
    if (started) apply_edge();
    started = 1;
    Reset = rst; Sel = s; A = a; B = b;
    push(nm);
    #2;
  endtask

  // Changes Sel between edges; C must follow without any clock edge.
  task automatic mid_sel(input logic s, input string nm);
    Sel = s;
    push(nm);
    #2;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      wait (exp_q.size() != 0);
      #1;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk({nm, ".C"},   {32'd0, C},          {32'd0, e.c});
      chk({nm, ".C_s"}, {56'd0, c_s},        {56'd0, e.c[7:0]});
      if (e.regs) begin
        chk({nm, ".C_q"},      {32'd0, C_q},      {32'd0, e.cq});
        chk({nm, ".Sel_q"},    {63'd0, Sel_q},    {63'd0, e.selq});
        chk({nm, ".B_count"},  {48'd0, B_count},  64'(e.cnt));
        chk({nm, ".C_q_s"},    {56'd0, cq_s},     {56'd0, e.cq[7:0]});
        chk({nm, ".Sel_q_s"},  {63'd0, selq_s},   {63'd0, e.selq});
        chk({nm, ".B_count_s"},{62'd0, bcnt_s},   64'(e.cnt_s));
      end
    end
  end

  initial begin : driver
    logic [31:0] ra, rb;
    logic        rs, rr;
    Reset = 1'b0; Sel = 1'b0; A = '0; B = '0;

    // Reset with Sel = 1: C still follows B; registers read 0 afterwards.
    step(1'b1, 1'b1, 32'h0000_3004, 32'h0000_3100, "reset_c");
    step(1'b0, 1'b0, 32'h0000_3004, 32'h0000_3100, "basic_sel0");
    mid_sel(1'b1, "basic_sel1_noedge");
    step(1'b0, 1'bx, 32'hDEAD_BEEF, 32'h1234_5678, "sel_x");

    // Observation pattern 1,0,1,1 after reset.
    step(1'b1, 1'b0, 32'h0000_3004, 32'h0000_3200, "obs_reset");
    step(1'b0, 1'b1, 32'h0000_3004, 32'h0000_3200, "obs_p0");
    step(1'b0, 1'b0, 32'h0000_3008, 32'h0000_3200, "obs_p1");
    step(1'b0, 1'b1, 32'h0000_300C, 32'h0000_3200, "obs_p2");
    step(1'b0, 1'b1, 32'h0000_3010, 32'h0000_3200, "obs_p3");
    step(1'b0, 1'b0, 32'h0000_3014, 32'h0000_3200, "obs_end");

    // Saturation of the 2-bit counter: 1,2,3,3,3.
    step(1'b1, 1'b0, 32'h0, 32'h0, "sat_reset");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 32'h40 + i, 32'h80 + i, "sat");

    // Reset mid-run with Sel = 1 is not counted; counting restarts from 0.
    step(1'b1, 1'b0, 32'h0, 32'h0, "mid_reset0");
    step(1'b0, 1'b1, 32'h1, 32'h2, "mid_cnt1");
    step(1'b0, 1'b1, 32'h3, 32'h4, "mid_cnt2");
    step(1'b1, 1'b1, 32'h5, 32'h6, "mid_rst");
    step(1'b0, 1'b1, 32'h7, 32'h8, "mid_release");
    step(1'b0, 1'b0, 32'h9, 32'hA, "mid_after");

    // Randomized traffic with occasional resets and mid-cycle select changes.
    for (int i = 0; i < 300; i++) begin
      ra = $urandom; rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 31) == 0);
      step(rr, rs, ra, rb, "rand");
      if ($urandom_range(0, 3) == 0) mid_sel(~rs, "rand_mid");
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, "final");

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge CLK);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
